// File: rtl/uart_cmd_pkg.sv
// Shared key codes, reply bytes, FSM state encoding and the hex-digit decoder
// used by the UART command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] GO         = 8'h7A;
  localparam logic [7:0] STOP       = 8'h78;
  localparam logic [7:0] CLEAR      = 8'h63;
  localparam logic [7:0] LEFT       = 8'h61;
  localparam logic [7:0] RIGHT      = 8'h64;
  localparam logic [7:0] UP         = 8'h77;
  localparam logic [7:0] DOWN       = 8'h73;
  localparam logic [7:0] RESET      = 8'h1B;
  localparam logic [7:0] SET_PREFIX = 8'h53;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [1:0] {IDLE, GET_IDX, GET_VAL} state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } hex_digit_t;

  // Only upper-case 'A'..'F' are accepted as hex digits.
  function automatic hex_digit_t hex_decode(input logic [7:0] b);
    hex_digit_t h;
    h.valid = 1'b0;
    h.value = 4'h0;
    if (b >= 8'h30 && b <= 8'h39) begin
      h.valid = 1'b1;
      h.value = 4'(b - 8'h30);
    end else if (b >= 8'h41 && b <= 8'h46) begin
      h.valid = 1'b1;
      h.value = 4'(b - 8'h37);
    end
    return h;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// UART-side handshake between uart_rx/uart_tx (master) and the command decoder (slave).
interface uart_cmd_decoder_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (output rx_done, rx_data, tx_busy, input tx_start, tx_data);
  modport slave  (input rx_done, rx_data, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYC cycles have elapsed.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && count_q != LAST) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes UART bytes into stopwatch/button pulses, switch toggles and 'S' set commands.
// Optional ACK/NAK replies to the transmitter are enabled by defining UART_CMD_ACK_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_SW     = 5,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TIMEOUT_MS = 100
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_decoder_if.slave uart,
  output logic [2:0]        stopwatch_cntl,
  output logic [4:0]        btn_cntl,
  output logic [NUM_SW-1:0] sw_cntl,
  output logic              cmd_err
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [NUM_SW-1:0] sw_q, sw_d;
  logic [2:0]        stopwatch_q, stopwatch_d;
  logic [4:0]        btn_q, btn_d;
  logic              err_q, err_d;
  logic              result_ok;
  logic              expired;
  hex_digit_t        hex;
  logic [NUM_SW-1:0] toggle_mask, new_idx_mask, set_mask;

  // One-hot switch select; all-zero means the index is out of range.
  function automatic logic [NUM_SW-1:0] idx_mask(input logic [3:0] i);
    logic [NUM_SW-1:0] m;
    m = '0;
    for (int j = 0; j < int'(NUM_SW); j++) begin
      if (i == 4'(j)) m[j] = 1'b1;
    end
    return m;
  endfunction

  assign hex          = hex_decode(uart.rx_data);
  assign toggle_mask  = idx_mask(4'(uart.rx_data - 8'h31));
  assign new_idx_mask = idx_mask(hex.value);
  assign set_mask     = idx_mask(idx_q);

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (uart.rx_done || state_q == IDLE),
    .enable  (state_q != IDLE),
    .expired (expired)
  );

  // A received byte always takes priority over a timeout expiring in the same cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sw_d        = sw_q;
    stopwatch_d = '0;
    btn_d       = '0;
    err_d       = 1'b0;
    result_ok   = 1'b0;
    if (uart.rx_done) begin
      case (state_q)
        IDLE: begin
          result_ok = 1'b1;
          case (uart.rx_data)
            GO:         stopwatch_d = 3'b001;
            STOP:       stopwatch_d = 3'b010;
            CLEAR:      stopwatch_d = 3'b100;
            LEFT:       btn_d = 5'b00001;
            RIGHT:      btn_d = 5'b00010;
            UP:         btn_d = 5'b00100;
            DOWN:       btn_d = 5'b01000;
            RESET:      btn_d = 5'b10000;
            SET_PREFIX: begin
              result_ok = 1'b0;
              state_d   = GET_IDX;
            end
            default: begin
              if (uart.rx_data >= 8'h31 && uart.rx_data <= 8'h39 && |toggle_mask) begin
                sw_d = sw_q ^ toggle_mask;
              end else begin
                result_ok = 1'b0;
                err_d     = 1'b1;
              end
            end
          endcase
        end
        GET_IDX: begin
          if (hex.valid && |new_idx_mask) begin
            idx_d   = hex.value;
            state_d = GET_VAL;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        GET_VAL: begin
          state_d = IDLE;
          if (uart.rx_data == 8'h30) begin
            sw_d      = sw_q & ~set_mask;
            result_ok = 1'b1;
          end else if (uart.rx_data == 8'h31) begin
            sw_d      = sw_q | set_mask;
            result_ok = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sw_q        <= '0;
      stopwatch_q <= '0;
      btn_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sw_q        <= sw_d;
      stopwatch_q <= stopwatch_d;
      btn_q       <= btn_d;
      err_q       <= err_d;
    end
  end

  assign stopwatch_cntl = stopwatch_q;
  assign btn_cntl       = btn_q;
  assign sw_cntl        = sw_q;
  assign cmd_err        = err_q;

`ifdef UART_CMD_ACK_EN
  logic       pending_q, pending_d;
  logic [7:0] pending_data_q, pending_data_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;

  // Single reply slot: a fresh result overwrites whatever has not been sent yet.
  always_comb begin
    pending_d      = pending_q;
    pending_data_d = pending_data_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    if (pending_q && !uart.tx_busy) begin
      tx_start_d = 1'b1;
      tx_data_d  = pending_data_q;
      pending_d  = 1'b0;
    end
    if (result_ok) begin
      pending_d      = 1'b1;
      pending_data_d = ACK;
    end else if (err_d) begin
      pending_d      = 1'b1;
      pending_data_d = NAK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= 1'b0;
      pending_data_q <= 8'h00;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
    end else begin
      pending_q      <= pending_d;
      pending_data_q <= pending_data_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
    end
  end

  assign uart.tx_start = tx_start_q;
  assign uart.tx_data  = tx_data_q;
`else
  logic unused_ack_inputs;
  assign unused_ack_inputs = uart.tx_busy | result_ok;
  assign uart.tx_start     = 1'b0;
  assign uart.tx_data      = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder (NUM_SW=5, 100-cycle timeout);
// the reply checks follow whether UART_CMD_ACK_EN is defined.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] stopwatch_cntl;
  logic [4:0] btn_cntl;
  logic [4:0] sw_cntl;
  logic       cmd_err;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder_if uart_bus();

  uart_cmd_decoder #(
    .NUM_SW     (5),
    .CLK_HZ     (100_000),
    .TIMEOUT_MS (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart           (uart_bus),
    .stopwatch_cntl (stopwatch_cntl),
    .btn_cntl       (btn_cntl),
    .sw_cntl        (sw_cntl),
    .cmd_err        (cmd_err)
  );

  // One-cycle rx_done strobe; returns on the negedge where the registered result is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_bus.rx_done = 1'b1;
    uart_bus.rx_data = b;
    @(negedge clk);
    uart_bus.rx_done = 1'b0;
    uart_bus.rx_data = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_bus.rx_done = 1'b0;
    uart_bus.rx_data = 8'h00;
    uart_bus.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({stopwatch_cntl, btn_cntl, cmd_err, uart_bus.tx_start} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_pulses got %h want 000", {stopwatch_cntl, btn_cntl, cmd_err, uart_bus.tx_start});
    end
    vectors++;
    if (sw_cntl !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL reset_sw got %b want 00000", sw_cntl);
    end
    vectors++;
    if (uart_bus.tx_data !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_tx_data got %h want 00", uart_bus.tx_data);
    end
  endtask

  task automatic test_pulse_keys();
    logic [7:0] keys [8] = '{8'h7A, 8'h78, 8'h63, 8'h61, 8'h64, 8'h77, 8'h73, 8'h1B};
    logic [7:0] exp  [8] = '{8'b001_00000, 8'b010_00000, 8'b100_00000, 8'b000_00001,
                             8'b000_00010, 8'b000_00100, 8'b000_01000, 8'b000_10000};
    for (int i = 0; i < 8; i++) begin
      send_byte(keys[i]);
      vectors++;
      if ({stopwatch_cntl, btn_cntl, cmd_err} !== {exp[i], 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL pulse_key_%h got %b want %b", keys[i], {stopwatch_cntl, btn_cntl, cmd_err}, {exp[i], 1'b0});
      end
      @(negedge clk);
      vectors++;
      if ({stopwatch_cntl, btn_cntl} !== 8'b0) begin
        miscompares++;
        $display("[TB] FAIL pulse_width_%h got %b want 00000000", keys[i], {stopwatch_cntl, btn_cntl});
      end
    end
  endtask

  task automatic test_toggle();
    logic [7:0] bytes  [6] = '{8'h33, 8'h33, 8'h39, 8'h35, 8'h36, 8'h35};
    logic [4:0] exp_sw [6] = '{5'b00100, 5'b00000, 5'b00000, 5'b10000, 5'b10000, 5'b00000};
    logic       exp_err[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i]);
      vectors++;
      if ({sw_cntl, cmd_err} !== {exp_sw[i], exp_err[i]}) begin
        miscompares++;
        $display("[TB] FAIL toggle_%0d got sw=%b err=%b want sw=%b err=%b", i, sw_cntl, cmd_err, exp_sw[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_set();
    logic [7:0] bytes  [23] = '{8'h53, 8'h34, 8'h31, 8'h53, 8'h34, 8'h30, 8'h53, 8'h47,
                                8'h31, 8'h31, 8'h53, 8'h35, 8'h53, 8'h32, 8'h37, 8'h53,
                                8'h41, 8'h53, 8'h30, 8'h31, 8'h53, 8'h30, 8'h30};
    logic [4:0] exp_sw [23] = '{5'b00000, 5'b00000, 5'b10000, 5'b10000, 5'b10000, 5'b00000,
                                5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000,
                                5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                                5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
    logic       exp_err[23] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 23; i++) begin
      send_byte(bytes[i]);
      vectors++;
      if ({sw_cntl, cmd_err} !== {exp_sw[i], exp_err[i]}) begin
        miscompares++;
        $display("[TB] FAIL set_step_%0d got sw=%b err=%b want sw=%b err=%b", i, sw_cntl, cmd_err, exp_sw[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    uart_bus.rx_done = 1'b1;
    uart_bus.rx_data = 8'h7A;
    @(negedge clk);
    uart_bus.rx_data = 8'h31;
    vectors++;
    if ({stopwatch_cntl, sw_cntl} !== {3'b001, 5'b00000}) begin
      miscompares++;
      $display("[TB] FAIL b2b_first got %b want 00100000", {stopwatch_cntl, sw_cntl});
    end
    @(negedge clk);
    uart_bus.rx_data = 8'h78;
    vectors++;
    if ({stopwatch_cntl, sw_cntl} !== {3'b000, 5'b00001}) begin
      miscompares++;
      $display("[TB] FAIL b2b_second got %b want 00000001", {stopwatch_cntl, sw_cntl});
    end
    @(negedge clk);
    uart_bus.rx_done = 1'b0;
    vectors++;
    if ({stopwatch_cntl, sw_cntl} !== {3'b010, 5'b00001}) begin
      miscompares++;
      $display("[TB] FAIL b2b_third got %b want 01000001", {stopwatch_cntl, sw_cntl});
    end
    @(negedge clk);
    uart_bus.rx_done = 1'b1;
    uart_bus.rx_data = 8'h53;
    @(negedge clk);
    uart_bus.rx_data = 8'h33;
    @(negedge clk);
    uart_bus.rx_data = 8'h31;
    @(negedge clk);
    uart_bus.rx_done = 1'b0;
    uart_bus.rx_data = 8'h00;
    vectors++;
    if ({sw_cntl, cmd_err} !== {5'b01001, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL b2b_set got sw=%b err=%b want sw=01001 err=0", sw_cntl, cmd_err);
    end
  endtask

  task automatic test_timeout();
    int  n;
    logic seen;
    send_byte(8'h53);
    n = 0;
    seen = 1'b0;
    while (n < 150 && !seen) begin
      @(negedge clk);
      n++;
      if (cmd_err) seen = 1'b1;
    end
    vectors++;
    if (!seen || n != 100) begin
      miscompares++;
      $display("[TB] FAIL timeout_latency got %0d cycles (seen=%b) want 100", n, seen);
    end
    @(negedge clk);
    vectors++;
    if ({sw_cntl, cmd_err} !== {5'b01001, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL timeout_after got sw=%b err=%b want sw=01001 err=0", sw_cntl, cmd_err);
    end
    send_byte(8'h31);
    vectors++;
    if ({sw_cntl, cmd_err} !== {5'b01000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL timeout_then_toggle got sw=%b err=%b want sw=01000 err=0", sw_cntl, cmd_err);
    end
    send_byte(8'h53);
    repeat (98) @(negedge clk);
    send_byte(8'h32);
    vectors++;
    if (cmd_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_byte_wins got err=%b want 0", cmd_err);
    end
    send_byte(8'h31);
    vectors++;
    if ({sw_cntl, cmd_err} !== {5'b01100, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL timeout_byte_wins_set got sw=%b err=%b want sw=01100 err=0", sw_cntl, cmd_err);
    end
  endtask

  task automatic test_ack();
    int starts;
    uart_bus.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
`ifdef UART_CMD_ACK_EN
    send_byte(8'h7A);
    vectors++;
    if (uart_bus.tx_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ack_early got tx_start=%b want 0", uart_bus.tx_start);
    end
    @(negedge clk);
    vectors++;
    if ({uart_bus.tx_start, uart_bus.tx_data} !== {1'b1, 8'h06}) begin
      miscompares++;
      $display("[TB] FAIL ack_send got start=%b data=%h want start=1 data=06", uart_bus.tx_start, uart_bus.tx_data);
    end
    @(negedge clk);
    vectors++;
    if (uart_bus.tx_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ack_width got tx_start=%b want 0", uart_bus.tx_start);
    end
    uart_bus.tx_busy = 1'b1;
    send_byte(8'h00);
    vectors++;
    if (cmd_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL nak_err got %b want 1", cmd_err);
    end
    starts = 0;
    repeat (50) begin
      @(negedge clk);
      if (uart_bus.tx_start) starts++;
    end
    vectors++;
    if (starts != 0) begin
      miscompares++;
      $display("[TB] FAIL nak_while_busy got %0d starts want 0", starts);
    end
    uart_bus.tx_busy = 1'b0;
    @(negedge clk);
    vectors++;
    if ({uart_bus.tx_start, uart_bus.tx_data} !== {1'b1, 8'h15}) begin
      miscompares++;
      $display("[TB] FAIL nak_send got start=%b data=%h want start=1 data=15", uart_bus.tx_start, uart_bus.tx_data);
    end
    uart_bus.tx_busy = 1'b1;
    send_byte(8'h7A);
    send_byte(8'h39);
    repeat (3) @(negedge clk);
    uart_bus.tx_busy = 1'b0;
    @(negedge clk);
    vectors++;
    if ({uart_bus.tx_start, uart_bus.tx_data} !== {1'b1, 8'h15}) begin
      miscompares++;
      $display("[TB] FAIL overwrite_send got start=%b data=%h want start=1 data=15", uart_bus.tx_start, uart_bus.tx_data);
    end
    starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (uart_bus.tx_start) starts++;
    end
    vectors++;
    if (starts != 0) begin
      miscompares++;
      $display("[TB] FAIL overwrite_single got %0d extra starts want 0", starts);
    end
`else
    send_byte(8'h7A);
    starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (uart_bus.tx_start) starts++;
    end
    vectors++;
    if (starts != 0 || uart_bus.tx_data !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL ack_disabled got %0d starts data=%h want 0 starts data=00", starts, uart_bus.tx_data);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int starts;
    uart_bus.tx_busy = 1'b1;
    send_byte(8'h7A);
    send_byte(8'h53);
    send_byte(8'h32);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    uart_bus.tx_busy = 1'b0;
    vectors++;
    if ({sw_cntl, stopwatch_cntl, btn_cntl, cmd_err, uart_bus.tx_start, uart_bus.tx_data} !== 23'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_state got sw=%b start=%b data=%h want all zero", sw_cntl, uart_bus.tx_start, uart_bus.tx_data);
    end
    starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (uart_bus.tx_start) starts++;
    end
    vectors++;
    if (starts != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_pending got %0d starts want 0", starts);
    end
    send_byte(8'h31);
    vectors++;
    if ({sw_cntl, cmd_err} !== {5'b00001, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_toggle got sw=%b err=%b want sw=00001 err=0", sw_cntl, cmd_err);
    end
  endtask

  initial begin
    test_reset();
    test_pulse_keys();
    test_toggle();
    test_set();
    test_back_to_back();
    test_timeout();
    test_ack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got no completion want finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
